// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline and the hazard controller: pipeline-stage
// status in (master drives), stall/flush/bubble controls out (slave drives).
interface hazard_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic                        memread_id_ex;
  logic                        memread_ex_mem;
  logic                        memwrite_ex_mem;
  logic [NUM_SRC*REG_AW-1:0]   src_regs_if_id;
  logic [NUM_SRC-1:0]          src_valid_if_id;
  logic [REG_AW-1:0]           dst_reg_id_ex;
  logic                        flush_req;

  logic                        hazard;
  logic                        stall_if;
  logic                        stall_id;
  logic                        bubble_ex;
  logic                        stall_mem;
  logic                        flush_if_id;
  logic                        flush_id_ex;
  logic                        flush_pending;

  modport master (
    output memread_id_ex, memread_ex_mem, memwrite_ex_mem,
           src_regs_if_id, src_valid_if_id, dst_reg_id_ex, flush_req,
    input  hazard, stall_if, stall_id, bubble_ex, stall_mem,
           flush_if_id, flush_id_ex, flush_pending
  );

  modport slave (
    input  memread_id_ex, memread_ex_mem, memwrite_ex_mem,
           src_regs_if_id, src_valid_if_id, dst_reg_id_ex, flush_req,
    output hazard, stall_if, stall_id, bubble_ex, stall_mem,
           flush_if_id, flush_id_ex, flush_pending
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use hazard detection, fixed-latency memory stall FSM and deferred flush.
// Optional macro HAZARD_X0_FILTER_EN: register address 0 never raises a hazard.
module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flush_pending_q, flush_pending_d;

  logic [NUM_SRC-1:0] src_hit;
  logic               match;
  logic               mem_op;
  logic               stall_mem;
  logic               flush_take;
  logic               hazard;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] src_addr;
      assign src_addr = bus.src_regs_if_id[gi*REG_AW +: REG_AW];
`ifdef HAZARD_X0_FILTER_EN
      assign src_hit[gi] = bus.src_valid_if_id[gi] && (src_addr == bus.dst_reg_id_ex)
                           && (src_addr != '0);
`else
      assign src_hit[gi] = bus.src_valid_if_id[gi] && (src_addr == bus.dst_reg_id_ex);
`endif
    end
  endgenerate

  assign match      = |src_hit;
  assign mem_op     = bus.memread_ex_mem | bus.memwrite_ex_mem;
  assign stall_mem  = (state_q == BUSY);
  // A flush waits out a memory stall, then wins over any load-use hazard.
  assign flush_take = (bus.flush_req | flush_pending_q) & ~stall_mem;
  assign hazard     = bus.memread_id_ex & match & ~flush_take;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d = BUSY;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // The held mem_op here is the instruction that just finished.
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    flush_pending_d = flush_pending_q;
    if (flush_take) begin
      flush_pending_d = 1'b0;
    end else if (bus.flush_req && stall_mem) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // Combinational outputs are masked too so nothing leaks out during reset.
  assign bus.hazard        = hazard & ~rst;
  assign bus.stall_if      = (hazard | stall_mem) & ~rst;
  assign bus.stall_id      = (hazard | stall_mem) & ~rst;
  assign bus.bubble_ex     = hazard & ~stall_mem & ~rst;
  assign bus.stall_mem     = stall_mem & ~rst;
  assign bus.flush_if_id   = flush_take & ~rst;
  assign bus.flush_id_ex   = flush_take & ~rst;
  assign bus.flush_pending = flush_pending_q & ~rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one DUT with MEM_LAT=2, one with MEM_LAT=4.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2)) bus2 ();
  hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2)) bus4 ();

  hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .MEM_LAT(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .MEM_LAT(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  task automatic clear_inputs();
    bus2.memread_id_ex   = 1'b0;
    bus2.memread_ex_mem  = 1'b0;
    bus2.memwrite_ex_mem = 1'b0;
    bus2.src_regs_if_id  = '0;
    bus2.src_valid_if_id = '0;
    bus2.dst_reg_id_ex   = '0;
    bus2.flush_req       = 1'b0;
    bus4.memread_id_ex   = 1'b0;
    bus4.memread_ex_mem  = 1'b0;
    bus4.memwrite_ex_mem = 1'b0;
    bus4.src_regs_if_id  = '0;
    bus4.src_valid_if_id = '0;
    bus4.dst_reg_id_ex   = '0;
    bus4.flush_req       = 1'b0;
  endtask

  // Leaves the caller just after a posedge with both resets released.
  task automatic do_reset();
    rst  = 1'b1;
    rst4 = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    rst4 = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst  = 1'b1;
    rst4 = 1'b1;
    clear_inputs();
    bus2.memread_id_ex   = 1'b1;
    bus2.dst_reg_id_ex   = 5'd5;
    bus2.src_regs_if_id  = {5'd5, 5'd5};
    bus2.src_valid_if_id = 2'b11;
    bus2.memread_ex_mem  = 1'b1;
    bus2.flush_req       = 1'b1;
    @(negedge clk);
    o = {bus2.hazard, bus2.stall_if, bus2.stall_id, bus2.bubble_ex,
         bus2.stall_mem, bus2.flush_if_id, bus2.flush_id_ex, bus2.flush_pending};
    tests++;
    if (o !== 8'b0) begin
      fails++;
      $display("FAIL reset_outputs_flush got %b exp %b", o, 8'b0);
    end
    bus2.flush_req = 1'b0;
    @(negedge clk);
    o = {bus2.hazard, bus2.stall_if, bus2.stall_id, bus2.bubble_ex,
         bus2.stall_mem, bus2.flush_if_id, bus2.flush_id_ex, bus2.flush_pending};
    tests++;
    if (o !== 8'b0) begin
      fails++;
      $display("FAIL reset_outputs_hazard got %b exp %b", o, 8'b0);
    end
    do_reset();
    @(negedge clk);
    o = {bus2.hazard, bus2.stall_if, bus2.stall_id, bus2.bubble_ex,
         bus2.stall_mem, bus2.flush_if_id, bus2.flush_id_ex, bus2.flush_pending};
    tests++;
    if (o !== 8'b0) begin
      fails++;
      $display("FAIL post_reset_idle got %b exp %b", o, 8'b0);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_load_use();
    logic [4:0] o;
    do_reset();
    bus2.memread_id_ex   = 1'b1;
    bus2.dst_reg_id_ex   = 5'd5;
    bus2.src_regs_if_id  = {5'd5, 5'd3};
    bus2.src_valid_if_id = 2'b11;
    @(negedge clk);
    o = {bus2.hazard, bus2.stall_if, bus2.stall_id, bus2.bubble_ex, bus2.stall_mem};
    tests++;
    if (o !== 5'b11110) begin
      fails++;
      $display("FAIL load_use_src1 got %b exp %b", o, 5'b11110);
    end
    bus2.src_valid_if_id = 2'b01;
    #1;
    o = {bus2.hazard, bus2.stall_if, bus2.stall_id, bus2.bubble_ex, bus2.stall_mem};
    tests++;
    if (o !== 5'b00000) begin
      fails++;
      $display("FAIL load_use_invalid got %b exp %b", o, 5'b00000);
    end
    bus2.src_regs_if_id = {5'd3, 5'd5};
    #1;
    o = {bus2.hazard, bus2.stall_if, bus2.stall_id, bus2.bubble_ex, bus2.stall_mem};
    tests++;
    if (o !== 5'b11110) begin
      fails++;
      $display("FAIL load_use_src0 got %b exp %b", o, 5'b11110);
    end
    bus2.dst_reg_id_ex = 5'd6;
    #1;
    tests++;
    if (bus2.hazard !== 1'b0) begin
      fails++;
      $display("FAIL dst_mismatch got %b exp %b", bus2.hazard, 1'b0);
    end
    bus2.dst_reg_id_ex = 5'd5;
    bus2.memread_id_ex = 1'b0;
    #1;
    tests++;
    if (bus2.hazard !== 1'b0) begin
      fails++;
      $display("FAIL no_load got %b exp %b", bus2.hazard, 1'b0);
    end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_flush_priority();
    logic [4:0] o;
    do_reset();
    bus2.memread_id_ex   = 1'b1;
    bus2.dst_reg_id_ex   = 5'd5;
    bus2.src_regs_if_id  = {5'd5, 5'd0};
    bus2.src_valid_if_id = 2'b10;
    bus2.flush_req       = 1'b1;
    @(negedge clk);
    o = {bus2.flush_if_id, bus2.flush_id_ex, bus2.hazard, bus2.bubble_ex, bus2.stall_if};
    tests++;
    if (o !== 5'b11000) begin
      fails++;
      $display("FAIL flush_over_hazard got %b exp %b", o, 5'b11000);
    end
    step();
    bus2.flush_req = 1'b0;
    @(negedge clk);
    o = {bus2.flush_if_id, bus2.flush_pending, bus2.hazard, bus2.bubble_ex, bus2.stall_if};
    tests++;
    if (o !== 5'b00111) begin
      fails++;
      $display("FAIL flush_no_pending got %b exp %b", o, 5'b00111);
    end
    $display("[TB] test_flush_priority done");
  endtask

  task automatic test_x0();
    logic exp_h;
`ifdef HAZARD_X0_FILTER_EN
    exp_h = 1'b0;
`else
    exp_h = 1'b1;
`endif
    do_reset();
    bus2.memread_id_ex   = 1'b1;
    bus2.dst_reg_id_ex   = 5'd0;
    bus2.src_regs_if_id  = {5'd7, 5'd0};
    bus2.src_valid_if_id = 2'b01;
    @(negedge clk);
    tests++;
    if (bus2.hazard !== exp_h) begin
      fails++;
      $display("FAIL x0_hazard got %b exp %b", bus2.hazard, exp_h);
    end
    $display("[TB] test_x0 done");
  endtask

  task automatic test_mem_stall();
    int exp_stall[7];
    logic [2:0] o;
    exp_stall = '{0, 1, 1, 0, 0, 1, 1};
    do_reset();
    bus2.memread_ex_mem = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      if (k == 1) begin
        bus2.memread_id_ex   = 1'b1;
        bus2.dst_reg_id_ex   = 5'd9;
        bus2.src_regs_if_id  = {5'd1, 5'd9};
        bus2.src_valid_if_id = 2'b01;
      end else begin
        bus2.memread_id_ex = 1'b0;
      end
      @(negedge clk);
      tests++;
      if (bus2.stall_mem !== 1'(exp_stall[k])) begin
        fails++;
        $display("FAIL held_read_stall cycle %0d got %b exp %b", k, bus2.stall_mem, 1'(exp_stall[k]));
      end
      if (k == 1) begin
        o = {bus2.hazard, bus2.stall_if, bus2.bubble_ex};
        tests++;
        if (o !== 3'b110) begin
          fails++;
          $display("FAIL hazard_during_stall got %b exp %b", o, 3'b110);
        end
      end
    end
    $display("[TB] test_mem_stall done");
  endtask

  task automatic test_back_to_back();
    int exp_stall[6];
    exp_stall = '{0, 1, 1, 0, 0, 0};
    do_reset();
    bus2.memwrite_ex_mem = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        step();
        bus2.memwrite_ex_mem = 1'b0;
      end
      @(negedge clk);
      tests++;
      if (bus2.stall_mem !== 1'(exp_stall[k])) begin
        fails++;
        $display("FAIL store_pulse_stall cycle %0d got %b exp %b", k, bus2.stall_mem, 1'(exp_stall[k]));
      end
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_flush_during_stall();
    logic [2:0] o;
    do_reset();
    bus2.memread_ex_mem = 1'b1;
    @(negedge clk);
    step();
    bus2.flush_req = 1'b1;
    @(negedge clk);
    o = {bus2.flush_if_id, bus2.flush_id_ex, bus2.flush_pending};
    tests++;
    if (o !== 3'b000) begin
      fails++;
      $display("FAIL flush_held_c1 got %b exp %b", o, 3'b000);
    end
    step();
    bus2.flush_req = 1'b0;
    @(negedge clk);
    o = {bus2.flush_if_id, bus2.flush_id_ex, bus2.flush_pending};
    tests++;
    if (o !== 3'b001) begin
      fails++;
      $display("FAIL flush_pending_c2 got %b exp %b", o, 3'b001);
    end
    step();
    @(negedge clk);
    o = {bus2.flush_if_id, bus2.flush_id_ex, bus2.stall_mem};
    tests++;
    if (o !== 3'b110) begin
      fails++;
      $display("FAIL flush_take_c3 got %b exp %b", o, 3'b110);
    end
    step();
    @(negedge clk);
    o = {bus2.flush_if_id, bus2.flush_id_ex, bus2.flush_pending};
    tests++;
    if (o !== 3'b000) begin
      fails++;
      $display("FAIL flush_done_c4 got %b exp %b", o, 3'b000);
    end
    $display("[TB] test_flush_during_stall done");
  endtask

  task automatic test_reset_mid_stall();
    logic [1:0] o;
    logic [7:0] all_o;
    do_reset();
    bus4.memread_ex_mem = 1'b1;
    @(negedge clk);
    step();
    bus4.flush_req = 1'b1;
    @(negedge clk);
    step();
    bus4.flush_req       = 1'b0;
    bus4.memread_id_ex   = 1'b1;
    bus4.dst_reg_id_ex   = 5'd5;
    bus4.src_regs_if_id  = {5'd5, 5'd2};
    bus4.src_valid_if_id = 2'b10;
    @(negedge clk);
    o = {bus4.stall_mem, bus4.flush_pending};
    tests++;
    if (o !== 2'b11) begin
      fails++;
      $display("FAIL lat4_before_rst got %b exp %b", o, 2'b11);
    end
    #1;
    rst4 = 1'b1;
    #1;
    all_o = {bus4.hazard, bus4.stall_if, bus4.stall_id, bus4.bubble_ex,
             bus4.stall_mem, bus4.flush_if_id, bus4.flush_id_ex, bus4.flush_pending};
    tests++;
    if (all_o !== 8'b0) begin
      fails++;
      $display("FAIL async_rst_clears got %b exp %b", all_o, 8'b0);
    end
    step();
    rst4                 = 1'b0;
    bus4.memread_id_ex   = 1'b0;
    bus4.src_valid_if_id = 2'b00;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      @(negedge clk);
      tests++;
      if (bus4.stall_mem !== ((k >= 1) && (k <= 4))) begin
        fails++;
        $display("FAIL lat4_restall cycle %0d got %b exp %b", k, bus4.stall_mem, ((k >= 1) && (k <= 4)));
      end
    end
    $display("[TB] test_reset_mid_stall done");
  endtask

  initial begin
    rst  = 1'b1;
    rst4 = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_flush_priority();
    test_x0();
    test_mem_stall();
    test_back_to_back();
    test_flush_during_stall();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
